debug_display_scanner: RTL and testbench

//   Parametrised debug readout for the single-cycle core. Selects one of NUM_CH probe words
//   (PC, ALU out, immediates, ...) and converts it to hex or decimal. Scans it onto a DIGITS-wide

---
 rtl/debug_display_scanner.sv | 188 ++++++++++++++++++
 tb/tb_debug_display_scanner.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_display_scanner.sv
// Debug readout: selects a probe channel, converts it to hex or BCD and scans it onto a
// multiplexed active-low seven-segment display with freeze and leading-zero blanking.
module debug_display_scanner #(
  parameter int unsigned NUM_CH      = 16,
  parameter int unsigned CH_W        = 32,
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter bit          LZB         = 1'b1,
  localparam int unsigned SelW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     ssdclk,
  input  logic                     rst,
  input  logic [NUM_CH*CH_W-1:0]   probe_bus,
  input  logic [SelW-1:0]          ch_sel,
  input  logic                     dec_mode,
  input  logic                     freeze,
  output logic [DIGITS-1:0]        AN,
  output logic [6:0]               segOut,
  output logic [15:0]              LED,
  output logic                     busy
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned DigW = $clog2(DIGITS);
  localparam int unsigned PreW = $clog2(REFRESH_DIV);
  localparam int unsigned CntW = $clog2(CH_W);
  localparam logic [DIGITS-1:0] OneHot0 = DIGITS'(1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [CH_W-1:0]   sample_q;
  logic              mode_q;
  logic [BcdW-1:0]   bcd_q, bcd_adj;
  logic              ovf_q;
  logic [CntW-1:0]   cnt_q;
  logic [BcdW-1:0]   disp_q;
  logic              disp_ovf_q;
  logic              disp_dec_q;
  logic [15:0]       led_q;
  logic [PreW-1:0]   presc_q, presc_d;
  logic [DigW-1:0]   dig_q, dig_d;
  logic [DIGITS-1:0] an_q;
  logic [CH_W-1:0]   sel_word;
  logic [DIGITS-1:0] lead;
  logic              seen;
  logic [3:0]        nibble;

  // FSM: state register
  always_ff @(posedge ssdclk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (!freeze) state_d = dec_mode ? StShift : StDone;
      StShift: if (cnt_q == CntW'(CH_W - 1)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state_q == StShift) || (state_q == StDone);
  end

  // Unpopulated select codes read as zero
  always_comb begin
    sel_word = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_sel == SelW'(k)) sel_word = probe_bus[k*CH_W +: CH_W];
    end
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge ssdclk or negedge rst) begin
    if (!rst) begin
      sample_q   <= '0;
      mode_q     <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      disp_q     <= '0;
      disp_ovf_q <= 1'b0;
      disp_dec_q <= 1'b0;
      led_q      <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (!freeze) begin
            sample_q <= sel_word;
            mode_q   <= dec_mode;
            bcd_q    <= '0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
            led_q    <= 16'(sel_word);
          end
        end
        StShift: begin
          bcd_q    <= {bcd_adj[BcdW-2:0], sample_q[CH_W-1]};
          sample_q <= {sample_q[CH_W-2:0], 1'b0};
          ovf_q    <= ovf_q | bcd_adj[BcdW-1];
          cnt_q    <= cnt_q + 1'b1;
        end
        StDone: begin
          // Display only ever changes here, so a half-converted value is never shown
          disp_q     <= mode_q ? bcd_q : BcdW'(sample_q);
          disp_ovf_q <= mode_q & ovf_q;
          disp_dec_q <= mode_q;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    presc_d = presc_q + 1'b1;
    dig_d   = dig_q;
    if (presc_q == PreW'(REFRESH_DIV - 1)) begin
      presc_d = '0;
      dig_d   = (dig_q == DigW'(DIGITS - 1)) ? '0 : dig_q + 1'b1;
    end
  end

  // AN decodes the next index so enable and segments switch on the same edge
  always_ff @(posedge ssdclk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      dig_q   <= '0;
      an_q    <= '1;
    end else begin
      presc_q <= presc_d;
      dig_q   <= dig_d;
      an_q    <= ~(OneHot0 << dig_d);
    end
  end

  always_comb begin
    seen = 1'b0;
    lead = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      seen    = seen | (disp_q[4*i +: 4] != 4'd0);
      lead[i] = ~seen;
    end
  end

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    nibble = disp_q[dig_q*4 +: 4];
    if (disp_ovf_q)                        segOut = 7'b0111111;
    else if (LZB && disp_dec_q && lead[dig_q]) segOut = 7'b1111111;
    else                                   segOut = glyph(nibble);
  end

  assign AN  = an_q;
  assign LED = led_q;

endmodule

// File: tb/tb_debug_display_scanner.sv
// Scoreboard bench: stimulus pushes model results, a monitor pops them when a conversion ends.
module tb_debug_display_scanner;

  localparam int NCH = 4, CW = 16, ND = 4, RD = 4;

  logic              clk = 1'b0, rst = 1'b0;
  logic [NCH*CW-1:0] probe = '0;
  logic [1:0]        ch_sel = '0;
  logic              dec_mode = 1'b0, freeze = 1'b1;
  logic [ND-1:0]     an1, an0;
  logic [6:0]        seg1, seg0;
  logic [15:0]       led1, led0;
  logic              busy1, busy0;

  always #5 clk = ~clk;

  debug_display_scanner #(.NUM_CH(NCH), .CH_W(CW), .DIGITS(ND), .REFRESH_DIV(RD), .LZB(1'b1))
    u_lzb (.ssdclk(clk), .rst(rst), .probe_bus(probe), .ch_sel(ch_sel), .dec_mode(dec_mode),
           .freeze(freeze), .AN(an1), .segOut(seg1), .LED(led1), .busy(busy1));

  debug_display_scanner #(.NUM_CH(NCH), .CH_W(CW), .DIGITS(ND), .REFRESH_DIV(RD), .LZB(1'b0))
    u_nolzb (.ssdclk(clk), .rst(rst), .probe_bus(probe), .ch_sel(ch_sel), .dec_mode(dec_mode),
             .freeze(freeze), .AN(an0), .segOut(seg0), .LED(led0), .busy(busy0));

  typedef struct packed {
    logic [27:0] g1;
    logic [27:0] g0;
    logic [15:0] led;
    logic [7:0]  blen;
  } exp_t;

  localparam logic [6:0] Dash = 7'b0111111, Blank = 7'b1111111;

  exp_t sb[$];
  exp_t last;
  int   n_chk = 0, n_pass = 0, n_done = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'b1000000;   1: return 7'b1111001;   2: return 7'b0100100;
      3: return 7'b0110000;   4: return 7'b0011001;   5: return 7'b0010010;
      6: return 7'b0000010;   7: return 7'b1111000;   8: return 7'b0000000;
      9: return 7'b0010000;  10: return 7'b0001000;  11: return 7'b0000011;
      12: return 7'b1000110; 13: return 7'b0100001;  14: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  // Reference: arithmetic on the value, no knowledge of the shifting algorithm
  function automatic exp_t model(input int v, input bit dec);
    exp_t e;
    int   p = 1;
    e.led  = 16'(v);
    e.blen = dec ? 8'(CW + 1) : 8'd1;
    for (int i = 0; i < ND; i++) begin
      if (!dec) begin
        e.g1[7*i +: 7] = glyph((v >> (4 * i)) & 15);
        e.g0[7*i +: 7] = glyph((v >> (4 * i)) & 15);
      end else if (v >= 10000) begin
        e.g1[7*i +: 7] = Dash;
        e.g0[7*i +: 7] = Dash;
      end else begin
        e.g0[7*i +: 7] = glyph((v / p) % 10);
        e.g1[7*i +: 7] = (i > 0 && v < p) ? Blank : glyph((v / p) % 10);
      end
      p = p * 10;
    end
    return e;
  endfunction

  // One full refresh pass; collects each digit's glyph as its enable comes round
  task automatic scan(output logic [27:0] s1, output logic [27:0] s0, output int bad);
    logic [3:0] seen_m = '0;
    int idx;
    s1  = '0;
    s0  = '0;
    bad = 0;
    for (int c = 0; c < ND * RD + 2; c++) begin
      @(negedge clk);
      case (an1)
        4'b1110: idx = 0;
        4'b1101: idx = 1;
        4'b1011: idx = 2;
        4'b0111: idx = 3;
        default: idx = -1;
      endcase
      if (an0 !== an1) bad++;
      if (idx < 0) bad++;
      else begin
        s1[7*idx +: 7] = seg1;
        s0[7*idx +: 7] = seg0;
        seen_m[idx]    = 1'b1;
      end
    end
    if (seen_m != 4'hF) bad++;
  endtask

  initial begin : monitor
    bit prev = 1'b0;
    int blen = 0;
    int bad;
    exp_t e;
    logic [27:0] s1, s0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev = 1'b0;
        blen = 0;
      end else begin
        if (busy1) blen++;
        else if (prev) begin
          if (sb.size() == 0) chk("unexpected_update", 32'd1, 32'd0);
          else begin
            e = sb.pop_front();
            chk("busy_len", blen, e.blen);
            chk("led_lzb", led1, e.led);
            chk("led_nolzb", led0, e.led);
            scan(s1, s0, bad);
            chk("scan_an", bad, 0);
            chk("digits_lzb", s1, e.g1);
            chk("digits_nolzb", s0, e.g0);
          end
          blen = 0;
          n_done++;
        end
        prev = busy1;
      end
    end
  end

  task automatic xact(input int ch, input int v, input bit dec);
    int start = n_done;
    for (int k = 0; k < NCH; k++) probe[k*CW +: CW] = 16'($urandom);
    probe[ch*CW +: CW] = 16'(v);
    ch_sel   = 2'(ch);
    dec_mode = dec;
    last     = model(v, dec);
    sb.push_back(last);
    @(posedge clk); #1 freeze = 1'b0;
    @(posedge clk); #1 freeze = 1'b1;
    for (int c = 0; c < 200 && n_done == start; c++) @(posedge clk);
    if (n_done == start) begin
      chk("update_timeout", 32'd0, 32'd1);
      sb.delete();
    end
  endtask

  initial begin : stim
    logic [27:0] s1, s0;
    logic [3:0]  pa;
    int bad, run, v;
    bit first;
    logic [27:0] zeros;
    for (int i = 0; i < ND; i++) zeros[7*i +: 7] = glyph(0);

    #12;
    chk("reset_an", an1, 4'hF);
    chk("reset_busy", busy1, 1'b0);
    chk("reset_led", led1, 16'h0);
    chk("reset_seg", seg1, glyph(0));
    #6 rst = 1'b1;
    @(posedge clk); #1;
    chk("first_edge_an", an1, 4'b1110);

    pa = an1;
    run = 0;
    first = 1'b1;
    for (int c = 0; c < ND * RD * 2 + 2; c++) begin
      @(negedge clk);
      if (an1 == pa) run++;
      else begin
        chk("an_next", an1, {pa[2:0], pa[3]});
        if (!first) chk("an_hold", run, RD);
        first = 1'b0;
        pa = an1;
        run = 1;
      end
    end
    scan(s1, s0, bad);
    chk("post_reset_digits", s1, zeros);

    xact(2, 16'hBEEF, 1'b0);
    xact(1, 1234, 1'b1);
    xact(0, 12345, 1'b1);
    xact(3, 99, 1'b1);
    xact(2, 7, 1'b1);
    xact(0, 0, 1'b1);
    xact(1, 9999, 1'b1);
    xact(2, 10000, 1'b1);
    xact(3, 65535, 1'b0);
    xact(0, 16'h0A0B, 1'b0);
    for (int n = 0; n < 20; n++) begin
      case ($urandom_range(0, 4))
        0: v = $urandom_range(0, 9);
        1: v = $urandom_range(10, 99);
        2: v = $urandom_range(100, 999);
        3: v = $urandom_range(1000, 9999);
        default: v = $urandom_range(0, 65535);
      endcase
      xact($urandom_range(0, NCH - 1), v, 1'($urandom));
    end

    // Frozen: new probe data must not reach display or LED
    xact(1, 4321, 1'b1);
    for (int k = 0; k < NCH; k++) probe[k*CW +: CW] = 16'h1111;
    repeat (1000) @(posedge clk);
    scan(s1, s0, bad);
    chk("freeze_digits", s1, last.g1);
    chk("freeze_led", led1, last.led);
    xact(1, 16'h1111, 1'b1);

    // Reset in the middle of a decimal conversion
    probe[0 +: CW] = 16'd5678;
    ch_sel   = 2'd0;
    dec_mode = 1'b1;
    @(posedge clk); #1 freeze = 1'b0;
    @(posedge clk); #1 freeze = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("busy_mid_shift", busy1, 1'b1);
    rst = 1'b0;
    #1;
    chk("abort_an", an1, 4'hF);
    chk("abort_busy", busy1, 1'b0);
    chk("abort_led", led1, 16'h0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    scan(s1, s0, bad);
    chk("abort_digits_lzb", s1, zeros);
    chk("abort_digits_nolzb", s0, zeros);

    xact(3, 314, 1'b1);
    chk("queue_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
